// File: rtl/noc_pe_traffic_node.sv
// Processing-element traffic node for one local NoC port.
// It injects NUM_PKTS single-flit packets to pseudo-random remote PEs and counts and checks the flits it sinks.
module noc_pe_traffic_node #(
  parameter logic [1:0]  address  = 2'd0,
  parameter int          NUM_PKTS = 16,
  parameter int          INJ_GAP  = 4,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_data,
  input  logic        i_data_valid,
  output logic        o_data_ready,
  output logic [31:0] o_data,
  output logic        o_data_valid,
  input  logic        i_data_ready,
  output logic [15:0] o_sent_cnt,
  output logic [31:0] o_rcvd_cnt,
  output logic [15:0] o_err_cnt,
  output logic        o_done
);

  localparam logic [15:0] SEED_MIX = SEED ^ {14'b0, address};
  localparam logic [15:0] SEED_EFF = (SEED_MIX == 16'h0000) ? 16'h0001 : SEED_MIX;
  localparam logic [15:0] GAP_LAST = 16'(INJ_GAP);
  localparam logic [15:0] PKT_LAST = 16'(NUM_PKTS - 1);

  typedef enum logic [1:0] {GAP, SEND, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] gap_cnt;
  logic [15:0] lfsr;
  logic [11:0] seq;
  logic [15:0] sent_cnt;
  logic        handshake;
  logic [1:0]  dest;
  logic        rx_ready;
  logic [31:0] rcvd_cnt;
  logic [15:0] err_cnt;
  logic        rx_accept;
  logic        rx_bad;
  logic        unused_rx_bits;

  assign handshake = (state == SEND) && i_data_ready;
  assign dest      = (lfsr[1:0] == address) ? address + 2'd1 : lfsr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= GAP;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      GAP:  if (gap_cnt == GAP_LAST) state_next = SEND;
      SEND: begin
        if (handshake) begin
          if (sent_cnt == PKT_LAST) state_next = DONE;
          else if (INJ_GAP == 0)    state_next = SEND;
          else                      state_next = GAP;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = GAP;
    endcase
  end

  // After reset the gap starts at 0 (INJ_GAP+1 cycles to first valid); after a handshake
  // it restarts at 1 so exactly INJ_GAP idle cycles separate consecutive flits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                gap_cnt <= '0;
    else if (state == GAP)  gap_cnt <= gap_cnt + 16'd1;
    else if (handshake)     gap_cnt <= 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr     <= SEED_EFF;
      seq      <= '0;
      sent_cnt <= '0;
    end else if (handshake) begin
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      seq      <= seq + 12'd1;
      sent_cnt <= sent_cnt + 16'd1;
    end
  end

  assign o_data_valid = (state == SEND);
  assign o_data       = (state == SEND) ? {dest, address, seq, lfsr} : 32'h0;
  assign o_done       = (state == DONE);
  assign o_sent_cnt   = sent_cnt;

  assign rx_accept      = i_data_valid && rx_ready;
  assign rx_bad         = (i_data[31:30] != address) || (i_data[29:28] == address);
  assign unused_rx_bits = ^i_data[27:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready <= 1'b0;
      rcvd_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      rx_ready <= 1'b1;
      if (rx_accept) begin
        rcvd_cnt <= rcvd_cnt + 32'd1;
        if (rx_bad && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  assign o_data_ready = rx_ready;
  assign o_rcvd_cnt   = rcvd_cnt;
  assign o_err_cnt    = err_cnt;

endmodule

// File: tb/tb_noc_pe_traffic_node.sv
// Directed bench for noc_pe_traffic_node: one node under direct control plus four nodes on a behavioural NoC.
module tb_noc_pe_traffic_node;

  localparam logic [1:0]  ADDR = 2'd2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_data;
  logic        i_data_valid;
  logic        o_data_ready;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        i_data_ready;
  logic [15:0] o_sent_cnt;
  logic [31:0] o_rcvd_cnt;
  logic [15:0] o_err_cnt;
  logic        o_done;

  always #5 clk = ~clk;

  noc_pe_traffic_node #(.address(ADDR), .NUM_PKTS(16), .INJ_GAP(0), .SEED(SEED)) dut (
    .clk(clk), .rst(rst),
    .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
    .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
    .o_sent_cnt(o_sent_cnt), .o_rcvd_cnt(o_rcvd_cnt), .o_err_cnt(o_err_cnt), .o_done(o_done)
  );

  // Four nodes on an idealised NoC: fixed-priority per destination, single-cycle delivery.
  logic        sysRst;
  logic [31:0] nOdata [4];
  logic [31:0] nDdata [4];
  logic [31:0] nRcvd  [4];
  logic [15:0] nSent  [4];
  logic [15:0] nErr   [4];
  logic [3:0]  nOvalid, nGrant, nRready, nDvalid, nDone;

  for (genvar g = 0; g < 4; g++) begin : gNode
    noc_pe_traffic_node #(.address(2'(g)), .NUM_PKTS(16), .INJ_GAP(1), .SEED(SEED)) u_node (
      .clk(clk), .rst(sysRst),
      .i_data(nDdata[g]), .i_data_valid(nDvalid[g]), .o_data_ready(nRready[g]),
      .o_data(nOdata[g]), .o_data_valid(nOvalid[g]), .i_data_ready(nGrant[g]),
      .o_sent_cnt(nSent[g]), .o_rcvd_cnt(nRcvd[g]), .o_err_cnt(nErr[g]), .o_done(nDone[g])
    );
  end

  always_comb begin
    nDvalid = '0;
    nGrant  = '0;
    for (int d = 0; d < 4; d++) nDdata[d] = '0;
    for (int d = 0; d < 4; d++) begin
      for (int s = 0; s < 4; s++) begin
        if (!nDvalid[d] && nOvalid[s] && nRready[d] && (nOdata[s][31:30] == 2'(d))) begin
          nDvalid[d] = 1'b1;
          nDdata[d]  = nOdata[s];
          nGrant[s]  = 1'b1;
        end
      end
    end
  end

  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] expQ [$];
  int          sysQ [$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return (s << 1) | {15'b0, fb};
  endfunction

  function automatic logic [15:0] effSeed(input logic [1:0] addr);
    logic [15:0] x;
    x = SEED ^ {14'b0, addr};
    return (x == 16'h0) ? 16'h0001 : x;
  endfunction

  function automatic logic [31:0] makeFlit(input logic [15:0] s, input logic [11:0] sq, input logic [1:0] addr);
    logic [1:0] d;
    d = s[1:0];
    if (d == addr) d = addr + 2'd1;
    return {d, addr, sq, s};
  endfunction

  task automatic pushExpected(input int n, input logic [1:0] addr);
    logic [15:0] s;
    s = effSeed(addr);
    for (int i = 0; i < n; i++) begin
      expQ.push_back(makeFlit(s, 12'(i), addr));
      s = lfsrStep(s);
    end
  endtask

  // Accepts n flits with ready held high, comparing each against the scoreboard.
  task automatic drainFlits(input int n, input int budget);
    int          got;
    int          cyc;
    logic [31:0] e;
    got = 0;
    cyc = 0;
    i_data_ready = 1'b1;
    while (got < n && cyc < budget) begin
      if (o_data_valid) begin
        e = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEADBEEF;
        checkOutput($sformatf("flit%0d", got), o_data, e);
        checkOutput("dest_not_self", {31'b0, o_data[31:30] == ADDR}, 32'd0);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput("drain_count", 32'(got), 32'(n));
  endtask

  task automatic applyStimulus(input logic [31:0] flit);
    i_data       = flit;
    i_data_valid = 1'b1;
    @(negedge clk);
    checkOutput("rx_ready", {31'b0, o_data_ready}, 32'd1);
    i_data_valid = 1'b0;
    i_data       = '0;
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] f;
    logic [15:0] st;
    int          cyc;
    int          sum;
    int          expRcvd [4];

    rst          = 1'b1;
    sysRst       = 1'b1;
    i_data       = '0;
    i_data_valid = 1'b0;
    i_data_ready = 1'b1;

    // Reset state and first-run injection with INJ_GAP=0.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_data",  o_data, 32'd0);
    checkOutput("rst_valid", {31'b0, o_data_valid}, 32'd0);
    checkOutput("rst_ready", {31'b0, o_data_ready}, 32'd0);
    checkOutput("rst_sent",  32'(o_sent_cnt), 32'd0);
    checkOutput("rst_rcvd",  o_rcvd_cnt, 32'd0);
    checkOutput("rst_err",   32'(o_err_cnt), 32'd0);
    checkOutput("rst_done",  {31'b0, o_done}, 32'd0);
    rst = 1'b0;
    #1 checkOutput("valid_at_release", {31'b0, o_data_valid}, 32'd0);
    @(negedge clk);
    checkOutput("first_valid", {31'b0, o_data_valid}, 32'd1);
    checkOutput("ready_after_release", {31'b0, o_data_ready}, 32'd1);
    expQ.delete();
    pushExpected(16, ADDR);
    drainFlits(16, 100);
    checkOutput("done_flag",   {31'b0, o_done}, 32'd1);
    checkOutput("done_sent",   32'(o_sent_cnt), 32'd16);
    checkOutput("done_valid",  {31'b0, o_data_valid}, 32'd0);

    // Backpressure: flit must hold for 10 cycles, then exactly one handshake.
    i_data_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expQ.delete();
    pushExpected(2, ADDR);
    held = expQ[0];
    checkOutput("bp_first", o_data, held);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_hold%0d", i), o_data, held);
      checkOutput("bp_valid", {31'b0, o_data_valid}, 32'd1);
    end
    i_data_ready = 1'b1;
    @(negedge clk);
    i_data_ready = 1'b0;
    void'(expQ.pop_front());
    checkOutput("bp_sent_one", 32'(o_sent_cnt), 32'd1);
    checkOutput("bp_next_flit", o_data, expQ[0]);
    checkOutput("bp_next_seq", 32'(o_data[27:16]), 32'd1);
    @(negedge clk);
    checkOutput("bp_no_extra", 32'(o_sent_cnt), 32'd1);

    // Asynchronous reset while a flit is pending.
    #2 rst = 1'b1;
    #1;
    checkOutput("async_valid", {31'b0, o_data_valid}, 32'd0);
    checkOutput("async_data",  o_data, 32'd0);
    checkOutput("async_ready", {31'b0, o_data_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expQ.delete();
    pushExpected(1, ADDR);
    checkOutput("restart_flit", o_data, expQ.pop_front());
    checkOutput("restart_seq", 32'(o_data[27:16]), 32'd0);
    checkOutput("restart_payload", 32'(o_data[15:0]), 32'(effSeed(ADDR)));

    // Receive side: 5 good flits, 2 misrouted, then one self-sourced alongside a send handshake.
    applyStimulus({2'd2, 2'd0, 12'h001, 16'h1111});
    applyStimulus({2'd2, 2'd1, 12'h002, 16'h2222});
    applyStimulus({2'd2, 2'd3, 12'h003, 16'h3333});
    applyStimulus({2'd2, 2'd0, 12'h004, 16'h4444});
    applyStimulus({2'd2, 2'd1, 12'h005, 16'h5555});
    applyStimulus({2'd0, 2'd1, 12'h006, 16'h6666});
    applyStimulus({2'd3, 2'd0, 12'h007, 16'h7777});
    checkOutput("rx_count", o_rcvd_cnt, 32'd7);
    checkOutput("rx_errs",  32'(o_err_cnt), 32'd2);
    i_data_ready = 1'b1;
    applyStimulus({2'd2, 2'd2, 12'h008, 16'h8888});
    i_data_ready = 1'b0;
    checkOutput("sim_rcvd", o_rcvd_cnt, 32'd8);
    checkOutput("sim_errs", 32'(o_err_cnt), 32'd3);
    checkOutput("sim_sent", 32'(o_sent_cnt), 32'd1);
    checkOutput("sim_seq",  32'(o_data[27:16]), 32'd1);

    // Four-node system run; expected per-node receive counts come from the flit model.
    for (int d = 0; d < 4; d++) expRcvd[d] = 0;
    for (int s = 0; s < 4; s++) begin
      st = effSeed(2'(s));
      for (int i = 0; i < 16; i++) begin
        f = makeFlit(st, 12'(i), 2'(s));
        expRcvd[f[31:30]]++;
        st = lfsrStep(st);
      end
    end
    for (int d = 0; d < 4; d++) sysQ.push_back(expRcvd[d]);
    sysRst = 1'b0;
    cyc = 0;
    while (nDone != 4'hF && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    checkOutput("sys_all_done", {28'b0, nDone}, 32'hF);
    sum = 0;
    for (int d = 0; d < 4; d++) begin
      sum += int'(nRcvd[d]);
      checkOutput($sformatf("sys_rcvd%0d", d), nRcvd[d], 32'(sysQ.pop_front()));
      checkOutput($sformatf("sys_err%0d", d),  32'(nErr[d]), 32'd0);
      checkOutput($sformatf("sys_sent%0d", d), 32'(nSent[d]), 32'd16);
    end
    checkOutput("sys_rcvd_sum", 32'(sum), 32'd64);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/noc_pe_traffic_node.md
Name: noc_pe_traffic_node

Overview:
- Processing-element traffic node attached to one local port of the 4-port hierarchical NoC.
- Injects a fixed number of single-flit packets to pseudo-random remote PEs over a valid/ready output stream.
- Sinks and checks every flit the NoC delivers to it, and exposes send/receive/error counters for the testbench scoreboard.

Parameters:
- address, 0, this PE's 2-bit node ID (0..3).
- NUM_PKTS, 16, number of packets injected before going idle (1..4095).
- INJ_GAP, 4, idle clock cycles between an accepted flit and the next valid (0 = back-to-back).
- SEED, 16'hACE1, LFSR base seed; effective seed = SEED ^ {14'b0, address}, forced to 16'h0001 if that is zero.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous active-high reset.
- i_data  in  32  flit from the NoC.
- i_data_valid  in  1  i_data valid.
- o_data_ready  out  1  PE can accept a flit.
- o_data  out  32  flit to the NoC.
- o_data_valid  out  1  o_data valid.
- i_data_ready  in  1  NoC accepts o_data.
- o_sent_cnt  out  16  flits accepted by the NoC.
- o_rcvd_cnt  out  32  flits accepted from the NoC.
- o_err_cnt  out  16  malformed or misrouted flits received.
- o_done  out  1  all NUM_PKTS injected.

Behaviour:
- Flit format:
  - [31:30] destination ID
  - [29:28] source ID (= address)
  - [27:16] 12-bit sequence number, starting at 0 and incrementing per sent flit
  - [15:0] payload = LFSR state at generation
- Reset (asynchronous, while rst=1): all outputs are 0, including o_data, o_data_valid, o_data_ready and all counters. LFSR loads the effective seed. FSM enters GAP with the gap counter cleared.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. It advances exactly once per accepted output flit.
- Destination selection:
  - dest = lfsr[1:0].
  - If dest == address, use (address+1) mod 4 instead.
  - A PE never targets itself.
- FSM:
  - GAP: count INJ_GAP cycles, then go to SEND. With INJ_GAP=0, SEND is entered on the next edge.
  - SEND:
    - o_data_valid=1 and o_data holds the generated flit.
    - o_data and o_data_valid stay stable until i_data_ready=1 on a rising edge; valid is never withdrawn without a handshake.
    - On handshake: o_sent_cnt++, seq++, LFSR advances.
    - Then go to DONE if o_sent_cnt reaches NUM_PKTS, else to GAP.
  - DONE: o_data_valid=0, o_done=1. The FSM stays here until reset.
- First valid: asserted INJ_GAP+1 cycles after reset deasserts.
- Receive side:
  - o_data_ready is a flop, cleared by reset and set to 1 on the first edge after reset release. It then stays 1 permanently; the PE never back-pressures.
  - A flit is accepted on any edge with i_data_valid && o_data_ready. On acceptance, o_rcvd_cnt increments by 1.
  - o_err_cnt increments by 1 (saturating at 16'hFFFF) if i_data[31:30] != address or i_data[29:28] == address.
- Simultaneous send and receive handshakes in the same cycle are independent; both counters update.
- o_rcvd_cnt wraps modulo 2^32. o_sent_cnt never exceeds NUM_PKTS.
- Reset asserted mid-operation aborts any pending flit immediately: valid drops asynchronously and all state reinitialises.

Test Plan:
1. Reset, then address=2, INJ_GAP=0, i_data_ready held 1:
   - first valid appears 1 cycle after reset release;
   - 16 consecutive flits with seq 0..15, source field 2, dest never 2;
   - o_done=1 and o_sent_cnt=16 afterwards.
2. Backpressure: hold i_data_ready=0 for 10 cycles while valid:
   - o_data stays bit-identical and valid stays 1;
   - releasing ready gives exactly one handshake and seq increments by 1.
3. Receive: drive 5 flits with dest=address and source≠address, then 2 flits with dest≠address:
   - o_rcvd_cnt=7, o_err_cnt=2;
   - o_data_ready=1 throughout.
4. Asynchronous reset mid-packet (valid=1, ready=0):
   - o_data_valid falls without a clock edge;
   - after release, seq restarts at 0 and the payload equals the first-run payload.
5. System check: four nodes (address 0..3) on the NoC with NUM_PKTS=16:
   - sum of o_rcvd_cnt = 64;
   - every o_err_cnt = 0;
   - all o_done=1.
